// File: rtl/hazard_stall_controller_pkg.sv
// hazard_stall_controller_pkg: shared cpu state encodings and register-file constants
package hazard_stall_controller_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MC_BUSY  = 2'b01,
    MEM_WAIT = 2'b10
  } state_e;
endpackage

// File: rtl/hazard_stall_controller_if.sv
// hazard_stall_controller_if: pipeline-side hazard inputs and stall/bubble/flush controls
interface hazard_stall_controller_if;
  import hazard_stall_controller_pkg::*;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rA_address;
  logic [REG_ADDR_W-1:0] id_rB_address;
  logic                  id_uses_rA;
  logic                  id_uses_rB;
  logic [REG_ADDR_W-1:0] ex_rD_address;
  logic                  ex_is_load;
  logic                  ex_mc_start;
  logic                  mem_req;
  logic                  mem_ready;
  logic                  branch_taken;
  logic                  stall_pc;
  logic                  stall_if_id;
  logic                  bubble_id_ex;
  logic                  stall_id_ex;
  logic                  stall_ex_mem;
  logic                  flush_if_id;
  logic [1:0]            state_out;
  modport master (
    output id_valid, id_rA_address, id_rB_address, id_uses_rA, id_uses_rB,
           ex_rD_address, ex_is_load, ex_mc_start, mem_req, mem_ready, branch_taken,
    input  stall_pc, stall_if_id, bubble_id_ex, stall_id_ex, stall_ex_mem,
           flush_if_id, state_out
  );
  modport slave (
    input  id_valid, id_rA_address, id_rB_address, id_uses_rA, id_uses_rB,
           ex_rD_address, ex_is_load, ex_mc_start, mem_req, mem_ready, branch_taken,
    output stall_pc, stall_if_id, bubble_id_ex, stall_id_ex, stall_ex_mem,
           flush_if_id, state_out
  );
endinterface

// File: rtl/hazard_stall_controller_mc_latency_counter.sv
// mc_latency_counter: loadable down-counter with zero flag, holds at zero
module mc_latency_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o
);
  logic [CNT_W-1:0] count_q, count_d;
  assign zero_o  = count_q == '0;
  assign count_o = count_q;
  // load wins over decrement; decrement stops at zero
  always_comb count_d = load_i ? load_val_i : (dec_i && !zero_o) ? count_q - CNT_W'(1) : count_q;
  // count register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use / multi-cycle / memory-wait stall, bubble and flush control
// Optional HAZARD_PERF_CNT_EN adds saturating perf counters as extra outputs.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 3
) (
  input logic clk,
  input logic rst_n,
  hazard_stall_controller_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_lu_stalls,
  output logic [31:0] perf_mc_stalls,
  output logic [31:0] perf_mem_stalls
`endif
);
  localparam bit               MC_MULTI = MC_LATENCY > 1;
  localparam logic [CNT_W-1:0] MC_LOAD  = CNT_W'(MC_LATENCY - 1);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero, cnt_load, cnt_dec;
  logic             wait_c, mc_hold, lu_hazard, lu_hit;
  assign lu_hazard = hz.id_valid && hz.ex_is_load && hz.ex_rD_address != ZERO_REG &&
                     ((hz.id_uses_rA && hz.id_rA_address == hz.ex_rD_address) ||
                      (hz.id_uses_rB && hz.id_rB_address == hz.ex_rD_address));
  // a memory wait holds everything until the data side answers
  assign wait_c   = rst_n && ((hz.mem_req && !hz.mem_ready) || (state_q == MEM_WAIT && !hz.mem_ready));
  // a pending multi-cycle op keeps the front end frozen, including the MEM_WAIT exit cycle
  assign mc_hold  = !wait_c && (state_q == MC_BUSY || (state_q == MEM_WAIT && !cnt_zero));
  assign lu_hit   = rst_n && !wait_c && state_q == RUN && lu_hazard;
  assign cnt_load = !wait_c && state_q == RUN && hz.ex_mc_start && MC_MULTI;
  assign cnt_dec  = !wait_c && state_q == MC_BUSY;
  assign hz.stall_pc     = wait_c || mc_hold || lu_hit;
  assign hz.stall_if_id  = wait_c || mc_hold || lu_hit;
  assign hz.stall_id_ex  = wait_c || mc_hold;
  assign hz.stall_ex_mem = wait_c;
  assign hz.bubble_id_ex = lu_hit;
  assign hz.flush_if_id  = rst_n && hz.branch_taken && !(wait_c || mc_hold || lu_hit);
  assign hz.state_out    = state_q;
  mc_latency_counter #(.CNT_W(CNT_W)) u_mc_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (cnt_load),
    .dec_i     (cnt_dec),
    .load_val_i(MC_LOAD),
    .count_o   (cnt),
    .zero_o    (cnt_zero)
  );
  // next state: memory wait first, then multi-cycle countdown, then resume
  always_comb
    state_d = wait_c               ? MEM_WAIT :
              (state_q == RUN)     ? (cnt_load ? MC_BUSY : RUN) :
              (state_q == MC_BUSY) ? ((cnt <= CNT_W'(1)) ? RUN : MC_BUSY) :
                                     (cnt_zero ? RUN : MC_BUSY);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_q, perf_mc_q, perf_mem_q;
  // saturating event counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_lu_q  <= '0;
      perf_mc_q  <= '0;
      perf_mem_q <= '0;
    end else begin
      perf_lu_q  <= perf_lu_q  + 32'(hz.bubble_id_ex && perf_lu_q != '1);
      perf_mc_q  <= perf_mc_q  + 32'(state_q == MC_BUSY && perf_mc_q != '1);
      perf_mem_q <= perf_mem_q + 32'(hz.stall_ex_mem && perf_mem_q != '1);
    end
  assign perf_lu_stalls  = perf_lu_q;
  assign perf_mc_stalls  = perf_mc_q;
  assign perf_mem_stalls = perf_mem_q;
`endif
endmodule
